xnor_test_sequencer: RTL and testbench

XNOR_TEST_SEQUENCER -- requirements
Module: xnor_test_sequencer

---
 rtl/xnor_test_sequencer.sv | 99 +++++++++
 tb/tb_xnor_test_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_test_sequencer.sv
// Built-in self-test sequencer for a 2-input XNOR gate: walks the four input
// vectors, holds each for DWELL cycles, checks the gate output and reports results.
module xnor_test_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state;
    logic [1:0] vec_idx;
    logic [7:0] dwell_cnt;
    logic [1:0] vec_next;
    logic       mismatch;

    assign vec_next = vec_idx + 2'd1;
    // dut_a/dut_b are registered, so they already hold the vector under test in CHECK
    assign mismatch = (dut_c != ~(dut_a ^ dut_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec_idx   <= 2'd0;
            dwell_cnt <= 8'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_idx   <= 2'd0;
                        dwell_cnt <= 8'd0;
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        dut_a     <= 1'b0;
                        dut_b     <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    dwell_cnt <= dwell_cnt + 8'd1;
                    if (dwell_cnt == DWELL_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_mask[vec_idx] <= 1'b1;
                        if (err_count != 3'd4) begin
                            err_count <= err_count + 3'd1;
                        end
                    end
                    if (vec_idx != 2'd3) begin
                        vec_idx   <= vec_next;
                        dwell_cnt <= 8'd0;
                        dut_a     <= vec_next[1];
                        dut_b     <= vec_next[0];
                        state     <= DRIVE;
                    end else begin
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    pass  <= (fail_mask == 4'd0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_test_sequencer.sv
// Scoreboard bench for xnor_test_sequencer: DWELL=4 and DWELL=1 instances driven
// against good and faulty gate models.
module tb_xnor_test_sequencer;

    typedef struct {
        logic       p;
        logic [2:0] e;
        logic [3:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    bit   sel = 1'b0;

    logic a4, b4, c4, busy4, done4, pass4;
    logic [2:0] err4;
    logic [3:0] mask4;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] mask1;

    logic oa, ob, obusy, odone, opass;
    logic [2:0] oerr;
    logic [3:0] omask;

    int checks = 0;
    int passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // gate models: 0 XNOR, 1 XOR, 2 stuck-at-1, 3 stuck-at-0
    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0: return ~(a ^ b);
            1: return a ^ b;
            2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign c4 = gate(mode, a4, b4);
    assign c1 = gate(mode, a1, b1);

    assign oa    = sel ? a1 : a4;
    assign ob    = sel ? b1 : b4;
    assign obusy = sel ? busy1 : busy4;
    assign odone = sel ? done1 : done4;
    assign opass = sel ? pass1 : pass4;
    assign oerr  = sel ? err1 : err4;
    assign omask = sel ? mask1 : mask4;

    xnor_test_sequencer #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .start(start & ~sel),
        .dut_a(a4), .dut_b(b4), .dut_c(c4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_mask(mask4)
    );

    xnor_test_sequencer #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start & sel),
        .dut_a(a1), .dut_b(b1), .dut_c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({oa, ob, obusy, odone, opass} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {oa, ob, obusy, odone, opass});
        else passed++;
        checks++;
        if ({oerr, omask} !== 7'b0) $display("FAIL reset_results got err=%0d mask=%b want 0/0000", oerr, omask);
        else passed++;
    endtask

    task automatic run_vectors(input int d, input int m, input bit repulse);
        exp_t e;
        int last, n, bad_ab, bad_busy;
        bit seen;
        logic [1:0] v;
        mode = m;
        sel = (d == 1);
        e.e = 3'd0;
        e.m = 4'd0;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            if (gate(m, v[1], v[0]) !== ~(v[1] ^ v[0])) begin
                e.m[k] = 1'b1;
                e.e = e.e + 3'd1;
            end
        end
        e.p = (e.m == 4'd0);
        sb.push_back(e);
        last = 4 * (d + 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        bad_ab = 0;
        bad_busy = 0;
        while (!seen && n <= last + 5) begin
            if (n < last) begin
                v = 2'(n / (d + 1));
                if (oa !== v[1] || ob !== v[0]) bad_ab++;
                if (obusy !== 1'b1 || odone !== 1'b0) bad_busy++;
            end else if (n == last) begin
                if (oa !== 1'b0 || ob !== 1'b0) bad_ab++;
                if (obusy !== 1'b1 || odone !== 1'b0) bad_busy++;
            end
            start = (repulse && n == d + 2);
            @(posedge clk);
            #1;
            n++;
            if (odone === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!seen || n != last + 1) $display("FAIL done_edge dwell=%0d mode=%0d got edge %0d (seen=%0d) want %0d", d, m, n, seen, last + 1);
        else passed++;
        checks++;
        if (bad_ab != 0) $display("FAIL vector_seq dwell=%0d mode=%0d got %0d bad cycles want 0", d, m, bad_ab);
        else passed++;
        checks++;
        if (bad_busy != 0) $display("FAIL busy_run dwell=%0d mode=%0d got %0d bad cycles want 0", d, m, bad_busy);
        else passed++;
        e = sb.pop_front();
        checks++;
        if (opass !== e.p || oerr !== e.e || omask !== e.m || obusy !== 1'b0)
            $display("FAIL result dwell=%0d mode=%0d got pass=%b err=%0d mask=%b busy=%b want pass=%b err=%0d mask=%b busy=0",
                     d, m, opass, oerr, omask, obusy, e.p, e.e, e.m);
        else passed++;
    endtask

    task automatic test_idle_stable();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (odone !== 1'b1 || opass !== 1'b0 || oerr !== 3'd4 || omask !== 4'hf)
            $display("FAIL idle_stable got done=%b pass=%b err=%0d mask=%b want 1/0/4/1111", odone, opass, oerr, omask);
        else passed++;
    endtask

    task automatic test_hold_start();
        int n;
        sel = 1'b0;
        mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (odone !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 21) $display("FAIL hold_done_edge got %0d want 21", n);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (odone !== 1'b0 || obusy !== 1'b1 || oa !== 1'b0 || ob !== 1'b0)
            $display("FAIL hold_restart got done=%b busy=%b ab=%b%b want 0/1/00", odone, obusy, oa, ob);
        else passed++;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int late_done;
        sel = 1'b0;
        mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (oa !== 1'b1 || ob !== 1'b0 || oerr !== 3'd1)
            $display("FAIL mid_run_state got ab=%b%b err=%0d want 10/1", oa, ob, oerr);
        else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({obusy, odone, opass, oa, ob} !== 5'b0 || oerr !== 3'd0 || omask !== 4'd0)
            $display("FAIL abort_clear got busy=%b done=%b pass=%b ab=%b%b err=%0d mask=%b want all 0",
                     obusy, odone, opass, oa, ob, oerr, omask);
        else passed++;
        late_done = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (odone !== 1'b0 || obusy !== 1'b0) late_done++;
        end
        checks++;
        if (late_done != 0) $display("FAIL abort_no_done got %0d active cycles want 0", late_done);
        else passed++;
        run_vectors(4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        run_vectors(4, 0, 1'b0);
        run_vectors(4, 1, 1'b0);
        test_idle_stable();
        run_vectors(4, 2, 1'b0);
        run_vectors(4, 3, 1'b0);
        run_vectors(4, 0, 1'b1);
        test_hold_start();
        test_reset_mid_run();
        run_vectors(1, 0, 1'b0);
        run_vectors(1, 2, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
